branch_predictor: RTL and testbench
===================================

# branch_predictor

Fetch-stage direction and target predictor: a direct-mapped table of 2-bit saturating counters with a tagged branch-target buffer (BTB). Each cycle it gives the fetch stage a taken/not-taken prediction and a next-PC for the current fetch address. It is trained by the resolved outcome the execute stage produces for every conditional branch. It also reports, one cycle after resolution, whether the carried prediction was wrong.

## Interface
Parameters:
- ENTRIES, 64, number of table entries; power of two, ≥4
- PC_W, 32, PC width
- IDX_W, $clog2(ENTRIES), index width (derived)
- TAG_W, PC_W-IDX_W-2, tag width (derived)

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- fetch_pc  input  PC_W  PC being fetched this cycle
- pred_hit  output  1  fetch_pc hits a valid BTB entry (combinational)
- pred_taken  output  1  predicted taken (combinational)
- pred_target  output  PC_W  predicted next PC (combinational)
- upd_valid  input  1  a conditional branch resolved this cycle
- upd_pc  input  PC_W  PC of the resolved branch
- upd_taken  input  1  resolved direction (branch-taken from execute)
- upd_target  input  PC_W  resolved taken target
- upd_pred_taken  input  1  prediction that was carried down the pipe for this branch
- mispredict  output  1  registered direction-mispredict pulse
- stat_branches  output  32  resolved-branch count
- stat_mispredicts  output  32  mispredict count

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]; pc[1:0] ignored.
- Per entry: valid (1), tag (TAG_W), target (PC_W), ctr (2).
- Lookup, combinational:
  - pred_hit = valid[idx] & (tag[idx] == fetch tag).
  - pred_taken = pred_hit & ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : fetch_pc + 4, with modulo 2^PC_W wrap.
- Update, on rising clock edge when upd_valid=1:
  - Hit (valid and tag match): ctr increments if upd_taken, else decrements, saturating at 3 and 0. If upd_taken, target <= upd_target.
  - Miss and upd_taken: allocate by overwriting the slot. Set valid=1, tag=upd tag, target=upd_target, ctr=2'b10.
  - Miss and !upd_taken: no table change.
- mispredict <= upd_valid & (upd_taken != upd_pred_taken). Direction only; a target mismatch is not flagged.
- Stats (see Configuration):
  - stat_branches increments on each upd_valid.
  - stat_mispredicts increments on each upd_valid with a direction mismatch.
  - Both saturate at 32'hFFFF_FFFF.

## Timing
- Reset (reset=0, asynchronous), all entries: valid=0, ctr=2'b01, tag=0, target=0.
- Reset values of outputs: mispredict=0; stat_branches=0; stat_mispredicts=0. pred_hit=0 and pred_taken=0 follow from the table.
- Lookup latency 0 cycles. Update becomes visible to lookups in the cycle after the upd_valid edge.
- Same-cycle lookup and update of the same index: the lookup returns pre-update contents (no bypass).
- mispredict is high for exactly the one cycle after an upd_valid cycle with a mismatch. Back-to-back mismatches keep it high continuously.
- upd_valid on consecutive cycles to the same entry: each update is applied in order, with no dropped training.
- Reset asserted mid-stream: everything clears immediately. An update sampled on the same edge that reset is low is discarded.
- Release of reset is synchronous to clock by the system. The first update is accepted on the first rising edge with reset=1.

## Configuration
- BP_STATS_EN defined: stat_branches and stat_mispredicts are live 32-bit saturating counters as in Operation.
- BP_STATS_EN not defined: both ports are driven constant 0 and no counter flops are built. Prediction and mispredict behaviour are identical with or without the macro.

## Test plan
- Reset then lookup: assert reset=0 for 2 cycles, fetch_pc=32'h0000_0100. Required: pred_hit=0, pred_taken=0, pred_target=32'h0000_0104, mispredict=0, stats=0.
- Allocate and predict: update upd_pc=32'h100, upd_taken=1, upd_target=32'h200, upd_pred_taken=0.
  - Next cycle: mispredict=1.
  - Lookup 32'h100: pred_hit=1, pred_taken=1 (ctr=2), pred_target=32'h200.
  - With BP_STATS_EN: stat_branches=1, stat_mispredicts=1.
- Hysteresis from the allocated entry (ctr=2):
  - One not-taken update at 32'h100 gives ctr=1 and pred_taken=0, with pred_hit still 1.
  - Three further taken updates give ctr=3; a fourth taken update leaves ctr at 3.
  - One not-taken update from ctr=3 leaves pred_taken=1.
- Aliasing (ENTRIES=64): after allocating 32'h100, lookup 32'h200 (same index 0, different tag) gives pred_hit=0 and pred_target=32'h204.
  - Taken update at 32'h200 replaces the entry; lookup 32'h100 then misses.
- Same-cycle conflict: in the cycle that upd_valid allocates 32'h100, fetch_pc=32'h100 gives pred_hit=0. In the following cycle it gives pred_hit=1.
- Reset mid-operation: with a trained entry and upd_valid=1, pulse reset=0 for one cycle.
  - Required: the entry is invalid afterwards, the update is not applied, mispredict=0, and stats=0.

Source files
------------

// File: rtl/branch_predictor.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | branch_predictor: direct-mapped 2-bit counter table with tagged BTB.    |
// | Optional BP_STATS_EN builds saturating branch/mispredict counters.      |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int PC_W    = 32,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = PC_W - IDX_W - 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [PC_W-1:0] fetch_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_pred_taken,
  output logic            mispredict,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [PC_W-1:0]  r_target [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];

  logic [IDX_W-1:0] w_fetch_idx;
  logic [TAG_W-1:0] w_fetch_tag;
  logic [IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;
  logic             w_upd_hit;
  logic             w_dir_miss;
  logic [1:0]       w_ctr_cur;
  logic [1:0]       w_ctr_next;
  logic             w_unused;

  assign w_fetch_idx = fetch_pc[IDX_W+1:2];
  assign w_fetch_tag = fetch_pc[PC_W-1:IDX_W+2];
  assign w_upd_idx   = upd_pc[IDX_W+1:2];
  assign w_upd_tag   = upd_pc[PC_W-1:IDX_W+2];
  // Byte offset within the instruction word never affects prediction.
  assign w_unused    = ^{fetch_pc[1:0], upd_pc[1:0]};

  assign pred_hit    = r_valid[w_fetch_idx] && (r_tag[w_fetch_idx] == w_fetch_tag);
  assign pred_taken  = pred_hit && r_ctr[w_fetch_idx][1];
  assign pred_target = pred_taken ? r_target[w_fetch_idx] : fetch_pc + PC_W'(4);

  assign w_upd_hit   = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
  assign w_dir_miss  = upd_valid && (upd_taken != upd_pred_taken);

  always_comb begin
    w_ctr_cur  = r_ctr[w_upd_idx];
    w_ctr_next = w_ctr_cur;
    if (upd_taken) begin
      if (w_ctr_cur != 2'b11) w_ctr_next = w_ctr_cur + 2'b01;
    end else begin
      if (w_ctr_cur != 2'b00) w_ctr_next = w_ctr_cur - 2'b01;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
    end else if (upd_valid) begin
      if (w_upd_hit) begin
        r_ctr[w_upd_idx] <= w_ctr_next;
        if (upd_taken) r_target[w_upd_idx] <= upd_target;
      end else if (upd_taken) begin
        // Not-taken misses never allocate, so cold branches stay out of the BTB.
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= upd_target;
        r_ctr[w_upd_idx]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) mispredict <= 1'b0;
    else        mispredict <= w_dir_miss;
  end

`ifdef BP_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (upd_valid && (r_stat_branches != 32'hFFFF_FFFF))
        r_stat_branches <= r_stat_branches + 32'd1;
      if (w_dir_miss && (r_stat_mispredicts != 32'hFFFF_FFFF))
        r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;
`else
  assign stat_branches    = 32'd0;
  assign stat_mispredicts = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_branch_predictor: directed and randomized checks against a model.    |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_branch_predictor;

  localparam int ENTRIES = 64;
  localparam int PC_W    = 32;
  localparam int IDX_W   = $clog2(ENTRIES);
`ifdef BP_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic            clock;
  logic            reset;
  logic [PC_W-1:0] fetch_pc;
  logic            pred_hit;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic [PC_W-1:0] upd_target;
  logic            upd_pred_taken;
  logic            mispredict;
  logic [31:0]     stat_branches;
  logic [31:0]     stat_mispredicts;

  int checks;
  int failures;

  branch_predictor #(.ENTRIES(ENTRIES), .PC_W(PC_W)) dut (
    .clock(clock), .reset(reset), .fetch_pc(fetch_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .mispredict(mispredict), .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: one record per slot, counter as a plain integer 0..3.
  bit          m_valid  [ENTRIES];
  logic [31:0] m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  bit          exp_mis;
  logic [31:0] exp_br;
  logic [31:0] exp_mp;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_taken(logic [31:0] pc);
    return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_next(logic [31:0] pc);
    return m_taken(pc) ? m_target[idx_of(pc)] : pc + 32'd4;
  endfunction

  function automatic logic [31:0] exp_stat_br();
    return STATS_ON ? exp_br : 32'd0;
  endfunction

  function automatic logic [31:0] exp_stat_mp();
    return STATS_ON ? exp_mp : 32'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
    end
    exp_mis = 0; exp_br = 0; exp_mp = 0;
  endtask

  task automatic model_update(logic [31:0] pc, bit tk, logic [31:0] tgt, bit ptk);
    int i;
    i = idx_of(pc);
    if (m_hit(pc)) begin
      m_ctr[i] = tk ? ((m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1)
                    : ((m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1);
      if (tk) m_target[i] = tgt;
    end else if (tk) begin
      m_valid[i] = 1; m_tag[i] = tag_of(pc); m_target[i] = tgt; m_ctr[i] = 2;
    end
    exp_mis = (tk != ptk);
    if (exp_br != 32'hFFFF_FFFF) exp_br = exp_br + 1;
    if (exp_mis && exp_mp != 32'hFFFF_FFFF) exp_mp = exp_mp + 1;
  endtask

  // Present one resolved branch across the next rising edge; returns 1ns after it.
  task automatic apply(logic [31:0] pc, bit tk, logic [31:0] tgt, bit ptk);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_pred_taken = ptk;
    @(posedge clock);
    model_update(pc, tk, tgt, ptk);
    #1;
    upd_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    upd_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    fetch_pc = 32'h0000_0100;
    reset = 1'b0;
    upd_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    checks++; if (pred_hit !== 1'b0) begin failures++; $display("FAIL rst_hit got=%0b exp=0", pred_hit); end
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL rst_taken got=%0b exp=0", pred_taken); end
    checks++; if (pred_target !== 32'h0000_0104) begin failures++; $display("FAIL rst_target got=%h exp=00000104", pred_target); end
    checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL rst_mispredict got=%0b exp=0", mispredict); end
    checks++; if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      failures++; $display("FAIL rst_stats got=%0d/%0d exp=0/0", stat_branches, stat_mispredicts); end
    reset = 1'b1;
    #1;
    checks++; if (pred_hit !== 1'b0) begin failures++; $display("FAIL rst_rel_hit got=%0b exp=0", pred_hit); end
  endtask

  task automatic test_allocate();
    fetch_pc = 32'h0000_0100;
    apply(32'h100, 1'b1, 32'h200, 1'b0);
    checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL alloc_mispredict got=%0b exp=1", mispredict); end
    checks++; if (pred_hit !== 1'b1) begin failures++; $display("FAIL alloc_hit got=%0b exp=1", pred_hit); end
    checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL alloc_taken got=%0b exp=1", pred_taken); end
    checks++; if (pred_target !== 32'h0000_0200) begin failures++; $display("FAIL alloc_target got=%h exp=00000200", pred_target); end
    checks++; if (stat_branches !== exp_stat_br() || stat_mispredicts !== exp_stat_mp()) begin
      failures++; $display("FAIL alloc_stats got=%0d/%0d exp=%0d/%0d", stat_branches, stat_mispredicts, exp_stat_br(), exp_stat_mp()); end
    @(posedge clock); #1;
    checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL alloc_pulse_end got=%0b exp=0", mispredict); end
  endtask

  task automatic test_hysteresis();
    // Directions applied to the ctr=2 entry and the required pred_taken after each.
    bit seq_tk  [6] = '{0, 1, 1, 1, 1, 0};
    bit seq_exp [6] = '{0, 1, 1, 1, 1, 1};
    fetch_pc = 32'h0000_0100;
    for (int s = 0; s < 6; s++) begin
      apply(32'h100, seq_tk[s], 32'h200, ~seq_tk[s]);
      checks++; if (pred_taken !== seq_exp[s] || pred_taken !== m_taken(fetch_pc)) begin
        failures++; $display("FAIL hyst_taken step=%0d got=%0b exp=%0b", s, pred_taken, seq_exp[s]); end
      checks++; if (pred_hit !== 1'b1) begin failures++; $display("FAIL hyst_hit step=%0d got=%0b exp=1", s, pred_hit); end
      checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL hyst_b2b_mispredict step=%0d got=%0b exp=1", s, mispredict); end
    end
  endtask

  task automatic test_aliasing();
    fetch_pc = 32'h0000_0200;
    #1;
    checks++; if (pred_hit !== 1'b0) begin failures++; $display("FAIL alias_hit got=%0b exp=0", pred_hit); end
    checks++; if (pred_target !== 32'h0000_0204) begin failures++; $display("FAIL alias_target got=%h exp=00000204", pred_target); end
    apply(32'h200, 1'b1, 32'h300, 1'b1);
    checks++; if (pred_hit !== 1'b1 || pred_target !== 32'h0000_0300) begin
      failures++; $display("FAIL alias_replace got=%0b/%h exp=1/00000300", pred_hit, pred_target); end
    fetch_pc = 32'h0000_0100;
    #1;
    checks++; if (pred_hit !== 1'b0) begin failures++; $display("FAIL alias_evicted got=%0b exp=0", pred_hit); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    fetch_pc = 32'h0000_0100;
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h200; upd_pred_taken = 1'b1;
    #1;
    checks++; if (pred_hit !== 1'b0) begin failures++; $display("FAIL same_cycle_pre got=%0b exp=0", pred_hit); end
    @(posedge clock);
    model_update(32'h100, 1'b1, 32'h200, 1'b1);
    #1;
    upd_valid = 1'b0;
    checks++; if (pred_hit !== 1'b1) begin failures++; $display("FAIL same_cycle_post got=%0b exp=1", pred_hit); end
    checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL same_cycle_mispredict got=%0b exp=0", mispredict); end
  endtask

  task automatic test_random();
    logic [31:0] pc;
    logic [31:0] fpc;
    bit          tk;
    bit          ptk;
    for (int n = 0; n < 400; n++) begin
      fpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC
          : (($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC
          : (($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      tk  = $urandom_range(0, 1);
      ptk = ($urandom_range(0, 3) == 0) ? ~m_taken(pc) : m_taken(pc);
      fetch_pc = fpc;
      #1;
      checks++; if (pred_hit !== m_hit(fpc) || pred_taken !== m_taken(fpc) || pred_target !== m_next(fpc)) begin
        failures++; $display("FAIL rand_lookup n=%0d pc=%h got=%0b/%0b/%h exp=%0b/%0b/%h", n, fpc,
          pred_hit, pred_taken, pred_target, m_hit(fpc), m_taken(fpc), m_next(fpc)); end
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clock);
        exp_mis = 0;
        #1;
      end else begin
        apply(pc, tk, {$urandom} & 32'hFFFF_FFFC, ptk);
      end
      checks++; if (mispredict !== exp_mis) begin failures++; $display("FAIL rand_mispredict n=%0d got=%0b exp=%0b", n, mispredict, exp_mis); end
      checks++; if (stat_branches !== exp_stat_br() || stat_mispredicts !== exp_stat_mp()) begin
        failures++; $display("FAIL rand_stats n=%0d got=%0d/%0d exp=%0d/%0d", n, stat_branches, stat_mispredicts, exp_stat_br(), exp_stat_mp()); end
    end
  endtask

  task automatic test_reset_mid();
    fetch_pc = 32'h0000_0100;
    apply(32'h100, 1'b1, 32'h200, 1'b0);
    checks++; if (pred_hit !== 1'b1) begin failures++; $display("FAIL mid_trained got=%0b exp=1", pred_hit); end
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h400; upd_pred_taken = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (pred_hit !== 1'b0 || mispredict !== 1'b0) begin
      failures++; $display("FAIL mid_async got=%0b/%0b exp=0/0", pred_hit, mispredict); end
    @(posedge clock);
    #1;
    reset = 1'b1;
    upd_valid = 1'b0;
    model_reset();
    #1;
    checks++; if (pred_hit !== 1'b0) begin failures++; $display("FAIL mid_entry got=%0b exp=0", pred_hit); end
    checks++; if (pred_target !== 32'h0000_0104) begin failures++; $display("FAIL mid_target got=%h exp=00000104", pred_target); end
    checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL mid_mispredict got=%0b exp=0", mispredict); end
    checks++; if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      failures++; $display("FAIL mid_stats got=%0d/%0d exp=0/0", stat_branches, stat_mispredicts); end
    apply(32'h100, 1'b1, 32'h500, 1'b1);
    checks++; if (pred_hit !== 1'b1 || pred_target !== 32'h0000_0500) begin
      failures++; $display("FAIL mid_first_update got=%0b/%h exp=1/00000500", pred_hit, pred_target); end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; fetch_pc = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0;
    model_reset();
    test_reset();
    test_allocate();
    test_hysteresis();
    test_aliasing();
    test_same_cycle();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
